program_loader: RTL and testbench
=================================

# program_loader

Boot-time writer for the nRisc instruction memory. It accepts a framed byte stream over a valid/ready handshake, writes the payload into instruction memory from address 0 upward, and verifies an 8-bit checksum. It holds the processor in reset until a load completes cleanly. It sits beside `instructions_memory` at the top level, as the write-side counterpart of the processor's fetch port.

## Interface
- `DATA_W`, default 8: instruction/byte width.
- `ADDR_W`, default 8: instruction memory address width; capacity 2^ADDR_W words.
- `TIMEOUT`, default 1024: maximum idle cycles between accepted bytes while a frame is open.
- `Clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  DATA_W  stream byte.
- `in_ready`  out  1  loader can accept a byte.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  DATA_W  write data.
- `cpu_hold`  out  1  processor reset request (1 = hold).
- `done`  out  1  last load succeeded.
- `error`  out  1  last load failed (checksum or timeout).

## Operation
- Frame format: LEN byte, then N payload bytes, then CHK byte.
  - N = LEN, except LEN = 0 means N = 2^ADDR_W.
  - CHK = sum of the payload bytes mod 2^DATA_W.
- States:
  - IDLE: on `start` go to LEN; clear `done`, `error`, checksum accumulator and address counter.
  - LEN: accept one byte and latch N; go to DATA.
  - DATA: each accepted byte is written to `imem_addr` = k, with k running 0..N-1. The byte is added to the accumulator. After byte N-1, go to CHECK.
  - CHECK: accept one byte. If it equals the accumulator, go to DONE; otherwise go to ERR.
  - DONE: `done`=1, `cpu_hold`=0. `start` begins a new frame: `cpu_hold` rises to 1 and the state goes to LEN.
  - ERR: `error`=1, `cpu_hold`=1. `start` goes to LEN.
- Transfers:
  - A byte transfers on a rising edge where `in_valid && in_ready`.
  - `in_ready` = 1 exactly in LEN, DATA and CHECK (registered state decode).
- Writes:
  - `imem_we`, `imem_addr` and `imem_wdata` are registered.
  - `imem_we` pulses exactly once per accepted DATA byte, and never for LEN or CHK.
- Timeout:
  - An idle counter clears on every transfer and on entry to LEN.
  - It increments each cycle in LEN, DATA or CHECK without a transfer.
  - When it reaches TIMEOUT, go to ERR; any pending write still completes.
- `start` asserted in LEN, DATA or CHECK is ignored.
- The address counter is ADDR_W+1 bits internally, so that N = 2^ADDR_W terminates correctly and writes never wrap to 0.

## Timing
- Reset values: state IDLE, `cpu_hold`=1, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `done`=0, `error`=0.
- Write latency: a DATA byte accepted at edge t drives `imem_we`=1 with its address and data during cycle t+1. The memory captures it at edge t+2.
- Back-to-back transfers are supported: one byte per cycle, one write per cycle.
- `cpu_hold` falls in the cycle after the CHK byte is accepted, the same cycle `done` rises. The last payload write has been driven no later than that cycle, so it is captured at or before the processor's first post-release edge.
- Reset asserted mid-frame aborts immediately, with all outputs at their reset values. Partially written memory contents are undefined, and `cpu_hold` remains 1.
- Timeout boundary: the transition to ERR happens on the edge where the counter equals TIMEOUT. A transfer on that same edge wins and clears the counter.

## Structure
- Shared package (`nrisc_pkg`): `DATA_W`/`ADDR_W` defaults and the loader state enum `loader_state_t` {IDLE, LEN, DATA, CHECK, DONE, ERR}.
- A single module; no sub-module. The checksum is a one-line adder and does not justify one.
- At top level, the processor reset is the AND of the external `reset` and `~cpu_hold`. Active-low reset matches this block's active-low convention.

## Test plan
- Basic load: `start`, then LEN=3, 0x11, 0x22, 0x33, CHK=0x66 at one byte per cycle.
  - Expect writes (0,0x11), (1,0x22), (2,0x33), one per cycle.
  - Expect `done`=1 and `cpu_hold`=0 one cycle after CHK.
- Bad checksum: LEN=2, 0xF0, 0x20, CHK=0x00 (correct sum is 0x10).
  - Expect two writes, then `error`=1, `cpu_hold`=1, `done`=0.
- Full memory: LEN=0 with 256 bytes, each equal to its index, CHK=0x80.
  - Expect 256 writes at addresses 0..255, no wrap, and `done`=1.
- Stalls and timeout, run with TIMEOUT=8:
  - Gaps of 7 idle cycles between bytes: load completes.
  - A gap of 8 idle cycles after the first payload byte: ERR, with exactly one write issued.
- Reset and restart:
  - Drive `reset`=0 after 2 payload bytes. Expect all outputs at their reset values in the same cycle.
  - After release, `start` and a full frame completes normally.
  - A `start` pulse during DATA has no effect.

Source files
------------

// File: rtl/nrisc_pkg.sv
// nrisc_pkg
// Shared definitions for the nRisc boot path: default data/address widths
// and the program loader state encoding.
package nrisc_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } loader_state_t;

    // A frame is open (bytes expected, idle timer running) in these states.
    function automatic logic is_open(input loader_state_t s);
        return (s == LEN) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/program_loader.sv
// program_loader
// Boot-time writer for the nRisc instruction memory. Accepts a framed byte
// stream (LEN, N payload bytes, CHK) over valid/ready, writes the payload to
// instruction memory from address 0 upward and verifies an 8-bit additive
// checksum. The processor is held in reset until a load completes cleanly.
//
// Ports:
//   Clock      single clock, rising edge
//   reset      asynchronous active-low reset
//   start      one-cycle load request, honoured in IDLE, DONE and ERR
//   in_valid   stream byte valid
//   in_data    stream byte
//   in_ready   loader accepts a byte (LEN, DATA, CHECK)
//   imem_we    registered instruction memory write strobe
//   imem_addr  registered write address
//   imem_wdata registered write data
//   cpu_hold   processor reset request (1 = hold)
//   done       last load succeeded
//   error      last load failed (checksum or timeout)
//
// At top level the processor reset is (reset & ~cpu_hold), both active-low.
module program_loader
    import nrisc_pkg::*;
#(
    parameter int DATA_W  = nrisc_pkg::DATA_W,
    parameter int ADDR_W  = nrisc_pkg::ADDR_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              Clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int IDLE_CNT_W = $clog2(TIMEOUT + 1);
    // Expiry fires on the edge that would take the idle count to TIMEOUT.
    localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(TIMEOUT - 1);
    localparam logic [IDLE_CNT_W-1:0] IDLE_ONE  = IDLE_CNT_W'(1);
    localparam logic [ADDR_W:0]       ADDR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]       FULL_LEN  = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t           state_r;
    // One bit wider than the memory address so a full 2^ADDR_W frame ends cleanly.
    logic [ADDR_W:0]         addr_r;
    logic [ADDR_W:0]         len_r;
    logic [DATA_W-1:0]       acc_r;
    logic [IDLE_CNT_W-1:0]   idle_r;

    logic                    xfer_s;
    logic                    expire_s;
    logic [ADDR_W-1:0]       len_lo_s;
    logic [ADDR_W:0]         len_s;

    // Handshake qualifier and idle-timeout expiry for the current cycle.
    always_comb begin
        xfer_s   = in_valid && in_ready;
        expire_s = is_open(state_r) && !xfer_s && (idle_r == IDLE_LAST);
    end

    // Decode the LEN byte: zero means the whole memory.
    always_comb begin
        len_lo_s = ADDR_W'(in_data);
        if (len_lo_s == {ADDR_W{1'b0}}) begin
            len_s = FULL_LEN;
        end else begin
            len_s = {1'b0, len_lo_s};
        end
    end

    // Loader FSM with registered handshake, write port and status outputs.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            addr_r     <= '0;
            len_r      <= '0;
            acc_r      <= '0;
            idle_r     <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (expire_s) begin
                // A write issued on an earlier edge is already on the port and completes.
                state_r  <= ERR;
                in_ready <= 1'b0;
                error    <= 1'b1;
                cpu_hold <= 1'b1;
                idle_r   <= '0;
            end else begin
                case (state_r)
                    IDLE, DONE, ERR: begin
                        if (start) begin
                            state_r  <= LEN;
                            in_ready <= 1'b1;
                            cpu_hold <= 1'b1;
                            done     <= 1'b0;
                            error    <= 1'b0;
                            acc_r    <= '0;
                            addr_r   <= '0;
                            idle_r   <= '0;
                        end
                    end
                    LEN: begin
                        if (xfer_s) begin
                            len_r   <= len_s;
                            idle_r  <= '0;
                            state_r <= DATA;
                        end else begin
                            idle_r <= idle_r + IDLE_ONE;
                        end
                    end
                    DATA: begin
                        if (xfer_s) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= addr_r[ADDR_W-1:0];
                            imem_wdata <= in_data;
                            acc_r      <= acc_r + in_data;
                            addr_r     <= addr_r + ADDR_ONE;
                            idle_r     <= '0;
                            if ((addr_r + ADDR_ONE) == len_r) begin
                                state_r <= CHECK;
                            end
                        end else begin
                            idle_r <= idle_r + IDLE_ONE;
                        end
                    end
                    CHECK: begin
                        if (xfer_s) begin
                            in_ready <= 1'b0;
                            idle_r   <= '0;
                            if (in_data == acc_r) begin
                                state_r  <= DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                            end else begin
                                state_r <= ERR;
                                error   <= 1'b1;
                            end
                        end else begin
                            idle_r <= idle_r + IDLE_ONE;
                        end
                    end
                    default: begin
                        // Unreachable encoding: fail safe with the processor held.
                        state_r  <= ERR;
                        in_ready <= 1'b0;
                        error    <= 1'b1;
                        cpu_hold <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
// Self-checking bench for program_loader. Frames are described as a list of
// stream bytes plus the idle gap before each byte; a small model derives the
// expected writes and final status from the frame rules (payload length,
// checksum sum mod 256, idle gap limit), and a monitor records every write.
module tb_program_loader;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TO = 8;

    logic          Clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int         wr_addr_q[$];
    int         wr_data_q[$];
    int         wr_cyc_q[$];
    logic [7:0] fr_g[$];
    int         gaps_g[$];

    program_loader #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .Clock      (Clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Write monitor: record every strobed write with the cycle it was seen.
    always @(negedge Clock) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(int'(imem_addr));
            wr_data_q.push_back(int'(imem_wdata));
            wr_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        in_valid = 1'b0;
        @(negedge Clock);
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
    endtask

    // Drive one byte after 'gap' idle cycles; returns the cycle it was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, output int acc_c, output bit ok);
        bit rdy;
        ok    = 1'b0;
        acc_c = -1;
        in_valid = 1'b0;
        repeat (gap) @(negedge Clock);
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < TO + 4; k++) begin
            rdy = in_ready;
            @(negedge Clock);
            if (rdy) begin
                ok    = 1'b1;
                acc_c = cyc;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Random frame of n payload bytes with optional bad checksum / forced timeout.
    task automatic build_frame(input int n, input bit good, input bit force_to);
        int         s;
        logic [7:0] b;
        fr_g.delete();
        gaps_g.delete();
        s = 0;
        b = 8'(n);
        fr_g.push_back(b);
        for (int k = 0; k < n; k++) begin
            b = 8'($urandom_range(0, 255));
            fr_g.push_back(b);
            s += int'(b);
        end
        b = 8'(s);
        if (!good) b = b ^ 8'($urandom_range(1, 255));
        fr_g.push_back(b);
        for (int k = 0; k < fr_g.size(); k++) begin
            gaps_g.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO - 1)) : 0);
        end
        if (force_to) gaps_g[$urandom_range(0, fr_g.size() - 1)] = TO;
    endtask

    // Run the frame in fr_g/gaps_g; start_at >= 0 raises start during that byte.
    task automatic run_frame(input string name, input int start_at);
        int  abort, n_pay, sum, exp_wr, last, acc_c;
        bit  ok, exp_done;
        int  acc_q[$];
        abort = -1;
        for (int i = 0; i < gaps_g.size(); i++) begin
            if (abort < 0 && gaps_g[i] >= TO) abort = i;
        end
        n_pay = (fr_g[0] == 8'd0) ? 256 : int'(fr_g[0]);
        sum = 0;
        for (int k = 1; k <= n_pay; k++) sum += int'(fr_g[k]);
        exp_done = (abort < 0) && ((sum % 256) == int'(fr_g[n_pay + 1]));
        if (abort < 0)       exp_wr = n_pay;
        else if (abort == 0) exp_wr = 0;
        else                 exp_wr = (abort - 1 < n_pay) ? abort - 1 : n_pay;

        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        pulse_start();
        n_tests++;
        if ({cpu_hold, in_ready, done, error} !== 4'b1100) begin
            n_fail++;
            $display("FAIL %s open: hold/ready/done/err got %b want 1100", name,
                     {cpu_hold, in_ready, done, error});
        end

        last = (abort < 0) ? fr_g.size() - 1 : abort - 1;
        for (int i = 0; i <= last; i++) begin
            if (i == start_at) start = 1'b1;
            send_byte(fr_g[i], gaps_g[i], acc_c, ok);
            start = 1'b0;
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s accept: byte %0d not accepted, got ready=%b want 1", name, i, in_ready);
                return;
            end
            if (i >= 1 && i <= n_pay) acc_q.push_back(acc_c);
        end

        if (abort >= 0) begin
            in_valid = 1'b0;
            repeat (TO - 1) @(negedge Clock);
            n_tests++;
            if (error !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s early_timeout: err/ready got %b%b want 01", name, error, in_ready);
            end
            @(negedge Clock);
        end

        n_tests++;
        if ({done, error, cpu_hold, in_ready} !== {exp_done, !exp_done, !exp_done, 1'b0}) begin
            n_fail++;
            $display("FAIL %s status: done/err/hold/ready got %b want %b", name,
                     {done, error, cpu_hold, in_ready}, {exp_done, !exp_done, !exp_done, 1'b0});
        end
        @(negedge Clock);

        n_tests++;
        if (wr_addr_q.size() != exp_wr) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d want %0d", name, wr_addr_q.size(), exp_wr);
        end
        for (int k = 0; k < wr_addr_q.size() && k < exp_wr; k++) begin
            n_tests++;
            if (wr_addr_q[k] != k || wr_data_q[k] != int'(fr_g[k + 1]) || wr_cyc_q[k] != acc_q[k]) begin
                n_fail++;
                $display("FAIL %s write[%0d]: got a=%0d d=%02h c=%0d want a=%0d d=%02h c=%0d", name, k,
                         wr_addr_q[k], wr_data_q[k], wr_cyc_q[k], k, fr_g[k + 1], acc_q[k]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clock);
        n_tests++;
        if ({cpu_hold, in_ready, imem_we, imem_addr, imem_wdata, done, error} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got hold=%b rdy=%b we=%b a=%h d=%h done=%b err=%b want 1 0 0 00 00 0 0",
                     cpu_hold, in_ready, imem_we, imem_addr, imem_wdata, done, error);
        end
        reset = 1'b1;
        repeat (2) @(negedge Clock);
        n_tests++;
        if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_hold: got rdy=%b hold=%b want 0 1", in_ready, cpu_hold);
        end
    endtask

    task automatic test_basic();
        fr_g   = {8'd3, 8'h11, 8'h22, 8'h33, 8'h66};
        gaps_g = {0, 0, 0, 0, 0};
        run_frame("basic", -1);
    endtask

    task automatic test_bad_checksum();
        fr_g   = {8'd2, 8'hF0, 8'h20, 8'h00};
        gaps_g = {0, 0, 0, 0};
        run_frame("bad_chk", -1);
    endtask

    task automatic test_full_memory();
        logic [7:0] b;
        fr_g.delete();
        gaps_g.delete();
        fr_g.push_back(8'd0);
        for (int k = 0; k < 256; k++) begin
            b = 8'(k);
            fr_g.push_back(b);
        end
        fr_g.push_back(8'h80);
        for (int k = 0; k < fr_g.size(); k++) gaps_g.push_back(0);
        run_frame("full_mem", -1);
    endtask

    task automatic test_stalls();
        build_frame(6, 1'b1, 1'b0);
        for (int k = 0; k < gaps_g.size(); k++) gaps_g[k] = TO - 1;
        run_frame("stall_7", -1);
    endtask

    task automatic test_timeout();
        fr_g   = {8'd4, 8'hA5, 8'h5A, 8'h01, 8'h02, 8'h02};
        gaps_g = {0, 0, TO, 0, 0, 0};
        run_frame("timeout", -1);
    endtask

    task automatic test_start_in_data();
        build_frame(5, 1'b1, 1'b0);
        gaps_g[2] = 2;
        run_frame("start_in_data", 2);
    endtask

    task automatic test_reset_midframe();
        int acc_c;
        bit ok1, ok2, ok3;
        pulse_start();
        send_byte(8'd5, 0, acc_c, ok1);
        send_byte(8'hA1, 0, acc_c, ok2);
        send_byte(8'hA2, 0, acc_c, ok3);
        n_tests++;
        if (!(ok1 && ok2 && ok3) || imem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_setup: got accepted=%b%b%b we=%b want 111 1", ok1, ok2, ok3, imem_we);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({cpu_hold, in_ready, imem_we, imem_addr, imem_wdata, done, error} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midframe_reset: got hold=%b rdy=%b we=%b a=%h d=%h done=%b err=%b want 1 0 0 00 00 0 0",
                     cpu_hold, in_ready, imem_we, imem_addr, imem_wdata, done, error);
        end
        @(negedge Clock);
        reset = 1'b1;
        build_frame(4, 1'b1, 1'b0);
        run_frame("after_reset", -1);
    endtask

    task automatic test_random();
        int  n;
        bit  good, tmo;
        for (int r = 0; r < 10; r++) begin
            n    = int'($urandom_range(1, 40));
            good = ($urandom_range(0, 3) != 0);
            tmo  = ($urandom_range(0, 4) == 0);
            build_frame(n, good, tmo);
            run_frame($sformatf("random%0d", r), -1);
        end
    endtask

    task automatic test_back_to_back();
        build_frame(3, 1'b1, 1'b0);
        run_frame("b2b_a", -1);
        build_frame(7, 1'b1, 1'b0);
        run_frame("b2b_b", -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_full_memory();
        test_stalls();
        test_timeout();
        test_start_in_data();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
